shift_op_dispatch: RTL
======================

Name: shift_op_dispatch

Overview:
Upstream issue stage for the shift/ALU execution unit.
- Buffers incoming operations (a, b, ctrl) in a small FIFO.
- Issues one operation at a time on the execution unit's operand inputs and holds them stable.
- Waits for the unit's out_en, captures its 32-bit out, and returns the result over a valid/ready interface.
- A bounded wait with a timeout flag keeps a missing out_en from hanging the pipeline.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
TIMEOUT, 15, max cycles spent in WAIT before aborting (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream op valid
in_ready  output  1  FIFO can accept (= !full)
in_a  input  32  operand a
in_b  input  5  shift amount / operand b
in_ctrl  input  5  operation select
ex_a  output  32  registered operand to execution unit
ex_b  output  5  registered shift amount to execution unit
ex_ctrl  output  5  registered op select to execution unit
ex_out_en  input  1  execution unit result valid
ex_out  input  32  execution unit result
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  32  captured result (0 on timeout)
res_timeout  output  1  qualifies res_data: op timed out
busy  output  1  high in WAIT or RESP

Behaviour:
- Reset (rst high at a clk edge): FIFO emptied; state=IDLE; wait counter=0.
- Outputs after reset: in_ready=1, ex_a=0, ex_b=0, ex_ctrl=0, res_valid=0, res_data=0, res_timeout=0, busy=0.
- Reset mid-operation discards all queued and in-flight ops. No result is produced for them.
- FIFO: push on in_valid && in_ready. Pop is internal only, in IDLE when not empty.
- FIFO: push and pop in the same cycle are both performed. Count is unchanged.
- FIFO: in_ready is computed from the current count only. There is no same-cycle bypass when full.
- FIFO: pointers wrap modulo DEPTH.
- FIFO: in_valid while full is ignored, and the op is not taken.
- FIFO: ops issue in arrival order.
- IDLE: if FIFO not empty, pop head into ex_a/ex_b/ex_ctrl, clear counter, go WAIT. Otherwise ex_* hold their last values.
- WAIT: ex_* held constant; busy=1. ex_out_en is sampled every WAIT cycle, starting the cycle after the pop.
- WAIT, ex_out_en=1: res_data<=ex_out, res_timeout<=0, res_valid<=1, go RESP.
- WAIT, else if counter==TIMEOUT-1: res_data<=0, res_timeout<=1, res_valid<=1, go RESP.
- WAIT, otherwise: counter+1.
- WAIT: ex_out_en on the same cycle as the timeout limit counts as success (ex_out_en has priority).
- RESP: res_valid=1; res_data and res_timeout held stable until res_ready.
- RESP: on res_valid && res_ready, res_valid<=0 and go IDLE.
- RESP: ex_out_en is ignored while in RESP or IDLE.
- Minimum issue-to-issue spacing is 3 cycles (IDLE -> WAIT -> RESP -> IDLE with immediate out_en and res_ready).
- Latency, in_valid accepted into empty idle block -> res_valid: 1 (FIFO write) + 1 (pop) + N (cycles until out_en) + 1 (capture) cycles.
- Counter width: ceil(log2(TIMEOUT+1)) bits. It never exceeds TIMEOUT-1.
- No combinational path from any input to any output except in_ready.

Test Plan:
- Reset then push a=59, b=3, ctrl=0; unit raises out_en with out=472 two cycles after issue; res_ready=1.
  -> ex_a=59, ex_b=3, ex_ctrl=0 held through WAIT; res_data=472, res_timeout=0, res_valid for exactly 1 cycle; busy back to 0.
- Push 5 ops back-to-back (a=1..5, b=1), DEPTH=4, unit responds after 1 cycle.
  -> in_ready drops once 4 entries are queued; 5th accepted only after the first pop.
  -> results 2,4,6,8,10 returned in order; no op lost or duplicated.
- Push a=0xFFFFFFFF, b=31; hold ex_out_en=0.
  -> after TIMEOUT=15 WAIT cycles: res_valid=1, res_timeout=1, res_data=0; next queued op then issues.
- Result backpressure: hold res_ready=0 for 10 cycles with out_en=1 and out=0x80000000.
  -> res_valid and res_data=0x80000000 stay stable for all 10 cycles; no new issue.
  -> pushes continue until full; res_ready=1 releases and the next op issues the following cycle.
- Simultaneous push and pop at count=4; then at count=3 with in_valid=1.
  -> full case: push refused, only pop occurs.
  -> count=3 case: count stays 3 and pointer wrap is correct over 3 laps.
- Assert rst while in WAIT with 3 ops queued.
  -> next cycle: all outputs at reset values, in_ready=1; a late ex_out_en produces no res_valid.

Source files
------------

// File: rtl/shift_op_dispatch.sv
// Issue stage for the shift/ALU unit: queues ops, issues one at a time, waits
// (bounded) for the unit's result and returns it over a valid/ready port.
module shift_op_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [4:0]  in_b,
    input  logic [4:0]  in_ctrl,
    output logic [31:0] ex_a,
    output logic [4:0]  ex_b,
    output logic [4:0]  ex_ctrl,
    input  logic        ex_out_en,
    input  logic [31:0] ex_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_timeout,
    output logic        busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned EW = 42;
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [31:0]    ex_a_q, ex_a_d;
    logic [4:0]     ex_b_q, ex_b_d;
    logic [4:0]     ex_ctrl_q, ex_ctrl_d;
    logic           res_valid_q, res_valid_d;
    logic [31:0]    res_data_q, res_data_d;
    logic           res_timeout_q, res_timeout_d;
    logic           push, pop;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        cnt_d         = cnt_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_ctrl_d     = ex_ctrl_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        push          = in_valid && in_ready;
        pop           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    {ex_a_d, ex_b_d, ex_ctrl_d} = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the limit cycle still wins over the timeout.
                if (ex_out_en) begin
                    res_data_d    = ex_out;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (cnt_q == WAIT_LIMIT) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_ctrl_q     <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_ctrl_q     <= ex_ctrl_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_ctrl};
        end
    end

endmodule
